// File: rtl/uart_rx.sv
// UART receiver. Oversamples the serial line on the rising edges of the 16x
// baud clock, rebuilds LSB-first data words, and reports each completed frame
// with a one-cycle rx_valid strobe. The strobe carries the data word and the
// parity and framing error flags.
module uart_rx #(
    parameter int DATA_BITS  = 8,
    parameter bit PARITY_EN  = 1'b0,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clk_16bd,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    // Parity check over the data word plus the received parity bit.
    // The result is forced to 0 when parity is disabled.
    function automatic logic parity_error(input logic [DATA_BITS-1:0] d, input logic pbit);
        parity_error = PARITY_EN & ((^{d, pbit}) != PARITY_ODD);
    endfunction

    logic                 rx_meta_r;
    logic                 rx_sync_r;
    logic                 c16_d_r;
    logic                 tick_s;
    state_t               state_r;
    state_t               state_nxt_s;
    logic [3:0]           tcnt_r;
    logic [3:0]           tcnt_nxt_s;
    logic [BW-1:0]        bcnt_r;
    logic [BW-1:0]        bcnt_nxt_s;
    logic [DATA_BITS-1:0] shift_r;
    logic [DATA_BITS-1:0] shift_nxt_s;
    logic                 pbit_r;
    logic                 pbit_nxt_s;
    logic                 done_s;

    // A single-cycle tick is produced on each rising edge of the 16x baud clock.
    assign tick_s = clk_16bd & ~c16_d_r;
    assign busy   = (state_r != IDLE);

    // Two-flop synchroniser for rx, plus the edge flop for the baud clock.
    // Both synchroniser flops reset to the idle line level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
            c16_d_r   <= 1'b0;
        end else begin
            rx_meta_r <= rx;
            rx_sync_r <= rx_meta_r;
            c16_d_r   <= clk_16bd;
        end
    end

    // Next-state logic for frame sequencing. Everything advances only on ticks.
    always_comb begin
        state_nxt_s = state_r;
        tcnt_nxt_s  = tcnt_r;
        bcnt_nxt_s  = bcnt_r;
        shift_nxt_s = shift_r;
        pbit_nxt_s  = pbit_r;
        done_s      = 1'b0;
        if (tick_s) begin
            tcnt_nxt_s = tcnt_r + 4'd1;
            case (state_r)
                IDLE: begin
                    tcnt_nxt_s = 4'd0;
                    if (!rx_sync_r) begin
                        state_nxt_s = START;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end
                START: begin
                    if (tcnt_r == 4'd7) begin
                        tcnt_nxt_s = 4'd0;
                        bcnt_nxt_s = '0;
                        // A line seen high at mid start bit is treated as a glitch.
                        if (rx_sync_r) begin
                            state_nxt_s = IDLE;
                        end else begin
                            state_nxt_s = DATA;
                        end
                    end else begin
                        state_nxt_s = START;
                    end
                end
                DATA: begin
                    if (tcnt_r == 4'd15) begin
                        shift_nxt_s = {rx_sync_r, shift_r[DATA_BITS-1:1]};
                        if (bcnt_r == BIT_LAST) begin
                            bcnt_nxt_s  = '0;
                            state_nxt_s = PARITY_EN ? PARITY : STOP;
                        end else begin
                            bcnt_nxt_s  = bcnt_r + BW'(1);
                            state_nxt_s = DATA;
                        end
                    end else begin
                        state_nxt_s = DATA;
                    end
                end
                PARITY: begin
                    if (tcnt_r == 4'd15) begin
                        pbit_nxt_s  = rx_sync_r;
                        state_nxt_s = STOP;
                    end else begin
                        state_nxt_s = PARITY;
                    end
                end
                STOP: begin
                    // Leaving at mid stop bit lets a back-to-back start bit be caught.
                    if (tcnt_r == 4'd15) begin
                        done_s      = 1'b1;
                        tcnt_nxt_s  = 4'd0;
                        state_nxt_s = IDLE;
                    end else begin
                        state_nxt_s = STOP;
                    end
                end
                default: begin
                    tcnt_nxt_s  = 4'd0;
                    state_nxt_s = IDLE;
                end
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    // Register the FSM state, the counters and the data path.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            tcnt_r  <= 4'd0;
            bcnt_r  <= '0;
            shift_r <= '0;
            pbit_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            tcnt_r  <= tcnt_nxt_s;
            bcnt_r  <= bcnt_nxt_s;
            shift_r <= shift_nxt_s;
            pbit_r  <= pbit_nxt_s;
        end
    end

    // Publish a completed frame. The flags and data hold until the next frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            rx_valid <= done_s;
            if (done_s) begin
                rx_data    <= shift_r;
                frame_err  <= ~rx_sync_r;
                parity_err <= parity_error(shift_r, pbit_r);
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx. It runs one 8N1 receiver and one 8E1
// receiver side by side. Every frame that is sent pushes its expected result,
// which is worked out from the line bits. The strobe monitor then compares
// each rx_valid pulse against the oldest expected entry.
module tb_uart_rx;

    typedef struct {
        logic [7:0] d;
        logic       pe;
        logic       fe;
    } frame_t;

    logic       clk      = 1'b0;
    logic       rst      = 1'b1;
    logic [1:0] div      = 2'd0;
    logic       clk_16bd;
    logic       rx       = 1'b1;
    logic       rx_p     = 1'b1;

    logic [7:0] rx_data,  rx_data_p;
    logic       rx_valid, rx_valid_p;
    logic       parity_err, parity_err_p;
    logic       frame_err,  frame_err_p;
    logic       busy,       busy_p;

    int n_checks = 0;
    int n_fail   = 0;

    frame_t exp_q[$];
    frame_t exp_qp[$];

    uart_rx #(.DATA_BITS(8), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)) dut (
        .clk(clk), .rst(rst), .clk_16bd(clk_16bd), .rx(rx),
        .rx_data(rx_data), .rx_valid(rx_valid), .parity_err(parity_err),
        .frame_err(frame_err), .busy(busy)
    );

    uart_rx #(.DATA_BITS(8), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) dut_p (
        .clk(clk), .rst(rst), .clk_16bd(clk_16bd), .rx(rx_p),
        .rx_data(rx_data_p), .rx_valid(rx_valid_p), .parity_err(parity_err_p),
        .frame_err(frame_err_p), .busy(busy_p)
    );

    always #5 clk = ~clk;

    // The 16x baud clock rises once every 4 clk, so one bit lasts 64 clk.
    always @(posedge clk) div <= div + 2'd1;
    assign clk_16bd = div[1];

    // Strobe scoreboard: each rx_valid pulse must match the oldest expected frame.
    always @(negedge clk) begin
        frame_t e;
        if (rx_valid === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL strobe_8n1: unexpected rx_valid data=%h pe=%b fe=%b", rx_data, parity_err, frame_err);
            end else begin
                e = exp_q.pop_front();
                if ({rx_data, parity_err, frame_err} !== {e.d, e.pe, e.fe}) begin
                    n_fail++;
                    $display("FAIL frame_8n1: got d=%h pe=%b fe=%b want d=%h pe=%b fe=%b",
                             rx_data, parity_err, frame_err, e.d, e.pe, e.fe);
                end
            end
        end
        if (rx_valid_p === 1'b1) begin
            n_checks++;
            if (exp_qp.size() == 0) begin
                n_fail++;
                $display("FAIL strobe_8e1: unexpected rx_valid data=%h pe=%b fe=%b", rx_data_p, parity_err_p, frame_err_p);
            end else begin
                e = exp_qp.pop_front();
                if ({rx_data_p, parity_err_p, frame_err_p} !== {e.d, e.pe, e.fe}) begin
                    n_fail++;
                    $display("FAIL frame_8e1: got d=%h pe=%b fe=%b want d=%h pe=%b fe=%b",
                             rx_data_p, parity_err_p, frame_err_p, e.d, e.pe, e.fe);
                end
            end
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_bit(input bit sel, input logic v);
        if (sel) rx_p = v; else rx = v;
        wait_clk(64);
    endtask

    // Sends one frame on the selected line and queues its expected result.
    // The parity bit is only sent on the parity line (sel=1), which uses even parity.
    task automatic send_frame(input bit sel, input logic [7:0] d, input logic pbit, input logic stop);
        frame_t e;
        e.d  = d;
        e.fe = ~stop;
        e.pe = sel && ((($countones(d) + int'(pbit)) % 2) != 0);
        if (sel) exp_qp.push_back(e); else exp_q.push_back(e);
        drive_bit(sel, 1'b0);
        for (int i = 0; i < 8; i++) drive_bit(sel, d[i]);
        if (sel) drive_bit(sel, pbit);
        drive_bit(sel, stop);
        if (sel) rx_p = 1'b1; else rx = 1'b1;
    endtask

    task automatic test_reset;
        wait_clk(3);
        n_checks++;
        if ({rx_data, rx_valid, parity_err, frame_err, busy} !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_8n1: got %h want 000", {rx_data, rx_valid, parity_err, frame_err, busy});
        end
        n_checks++;
        if ({rx_data_p, rx_valid_p, parity_err_p, frame_err_p, busy_p} !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_8e1: got %h want 000", {rx_data_p, rx_valid_p, parity_err_p, frame_err_p, busy_p});
        end
        rst = 1'b0;
        wait_clk(20);
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_busy: got %b want 0", busy);
        end
    endtask

    task automatic test_8n1;
        send_frame(1'b0, 8'h55, 1'b0, 1'b1);
        wait_clk(40);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL 8n1_count: %0d frames missing, want 0", exp_q.size());
        end
        n_checks++;
        if ({rx_data, rx_valid, frame_err} !== {8'h55, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL 8n1_hold: got d=%h v=%b fe=%b want d=55 v=0 fe=0", rx_data, rx_valid, frame_err);
        end
    endtask

    task automatic test_parity;
        send_frame(1'b1, 8'hA3, 1'b0, 1'b1);
        wait_clk(40);
        send_frame(1'b1, 8'hA3, 1'b1, 1'b1);
        wait_clk(40);
        n_checks++;
        if (exp_qp.size() != 0) begin
            n_fail++;
            $display("FAIL parity_count: %0d frames missing, want 0", exp_qp.size());
        end
        n_checks++;
        if (parity_err_p !== 1'b1) begin
            n_fail++;
            $display("FAIL parity_hold: got %b want 1", parity_err_p);
        end
    endtask

    task automatic test_false_start;
        rx = 1'b0;
        wait_clk(12);
        rx = 1'b1;
        wait_clk(8);
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL glitch_busy_hi: got %b want 1", busy);
        end
        wait_clk(40);
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL glitch_busy_lo: got %b want 0", busy);
        end
        n_checks++;
        if (rx_data !== 8'h55) begin
            n_fail++;
            $display("FAIL glitch_data_hold: got %h want 55", rx_data);
        end
    endtask

    task automatic test_frame_err;
        send_frame(1'b0, 8'h3C, 1'b0, 1'b0);
        wait_clk(100);
        n_checks++;
        if (frame_err !== 1'b1) begin
            n_fail++;
            $display("FAIL ferr_set: got %b want 1", frame_err);
        end
        send_frame(1'b0, 8'h81, 1'b0, 1'b1);
        wait_clk(40);
        n_checks++;
        if ({frame_err, exp_q.size() == 0} !== 2'b01) begin
            n_fail++;
            $display("FAIL ferr_clear: got fe=%b pending=%0d want fe=0 pending=0", frame_err, exp_q.size());
        end
    endtask

    task automatic test_back_to_back;
        send_frame(1'b0, 8'h01, 1'b0, 1'b1);
        send_frame(1'b0, 8'hFE, 1'b0, 1'b1);
        send_frame(1'b0, 8'h7E, 1'b0, 1'b1);
        wait_clk(40);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL b2b_count: %0d frames missing, want 0", exp_q.size());
        end
    endtask

    task automatic test_reset_mid;
        // Start 0xC3 (start bit, bit0=1), then reset halfway through bit1 (=1).
        rx = 1'b0;
        wait_clk(64);
        rx = 1'b1;
        wait_clk(96);
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_busy_before: got %b want 1", busy);
        end
        rst = 1'b1;
        wait_clk(1);
        n_checks++;
        if ({rx_data, rx_valid, parity_err, frame_err, busy} !== 12'h000) begin
            n_fail++;
            $display("FAIL rstmid_outputs: got %h want 000", {rx_data, rx_valid, parity_err, frame_err, busy});
        end
        wait_clk(1);
        rst = 1'b0;
        wait_clk(600);
        n_checks++;
        if ({rx_data, busy} !== 9'h000) begin
            n_fail++;
            $display("FAIL rstmid_after: got %h want 000", {rx_data, busy});
        end
        send_frame(1'b0, 8'h5A, 1'b0, 1'b1);
        wait_clk(40);
        n_checks++;
        if ({rx_data, exp_q.size() == 0} !== {8'h5A, 1'b1}) begin
            n_fail++;
            $display("FAIL rstmid_next: got d=%h pending=%0d want d=5a pending=0", rx_data, exp_q.size());
        end
    endtask

    task automatic test_random;
        for (int k = 0; k < 10; k++) begin
            bit         sel;
            logic [7:0] d;
            logic       pbit;
            logic       stop;
            sel  = 1'($urandom % 2);
            d    = 8'($urandom);
            pbit = 1'($urandom % 2);
            stop = (($urandom % 4) != 0);
            send_frame(sel, d, pbit, stop);
            wait_clk(100);
        end
        n_checks++;
        if ((exp_q.size() + exp_qp.size()) != 0) begin
            n_fail++;
            $display("FAIL random_count: %0d frames missing, want 0", exp_q.size() + exp_qp.size());
        end
    endtask

    initial begin
        test_reset();
        test_8n1();
        test_parity();
        test_false_start();
        test_frame_err();
        test_back_to_back();
        test_reset_mid();
        test_random();
        wait_clk(20);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
